// File: rtl/pbit_sampler.sv
// Two-stage p-bit sampler: m = sgn(clamp(beta*I) - r) with a valid/ready handshake,
// a force-clamp override and a saturating counter of output value changes.
module pbit_sampler #(
    parameter int I_W       = 16,
    parameter int I_FRAC    = 8,
    parameter int BETA_W    = 8,
    parameter int BETA_FRAC = 4,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [I_W-1:0] in_i,
    input  logic [BETA_W-1:0]     in_beta,
    input  logic [31:0]           rnd,
    input  logic                  clamp_en,
    input  logic                  clamp_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  m_out,
    output logic [CNT_W-1:0]      flip_cnt,
    input  logic                  cnt_clr
);

    localparam int P_W = I_W + BETA_W + 1;
    localparam int T_W = I_FRAC + 1;
    localparam logic signed [P_W-1:0] T_MAX = P_W'((1 << I_FRAC) - 1);
    localparam logic signed [P_W-1:0] T_MIN = ~T_MAX;

    logic                  adv1;
    logic                  adv2;
    logic                  vld_p1;
    logic signed [T_W-1:0] t_p1;
    logic                  clamp_en_p1;
    logic                  clamp_val_p1;
    logic                  last_m;
    logic signed [P_W-1:0] p_p0;
    logic signed [P_W-1:0] x_p0;
    logic signed [T_W-1:0] t_p0;
    logic signed [T_W-1:0] r_p1;
    logic                  m_p1;
    logic                  out_xfer;
    logic                  unused_rnd;

    // Hard-clamp approximation of tanh onto the comparator range.
    function automatic logic signed [T_W-1:0] sat_t(input logic signed [P_W-1:0] x);
        if (x > T_MAX)
            return $signed(T_MAX[T_W-1:0]);
        else if (x < T_MIN)
            return $signed(T_MIN[T_W-1:0]);
        else
            return $signed(x[T_W-1:0]);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~vld_p1 | adv2;
    assign in_ready = adv1;
    assign out_xfer = out_valid & out_ready;

    // The extra product bit keeps -2^(I_W-1) * (2^BETA_W-1) representable.
    assign p_p0 = $signed(in_i) * $signed({1'b0, in_beta});
    assign x_p0 = p_p0 >>> BETA_FRAC;
    assign t_p0 = sat_t(x_p0);

    assign r_p1       = $signed(rnd[31 -: T_W]);
    assign m_p1       = clamp_en_p1 ? clamp_val_p1 : (t_p1 > r_p1);
    assign unused_rnd = ^rnd[31-T_W:0];

    // ---- stage 1 data: clamped product and override, captured on input transfer
    always_ff @(posedge clk) begin
        if (in_valid && adv1) begin
            t_p1         <= t_p0;
            clamp_en_p1  <= clamp_en;
            clamp_val_p1 <= clamp_val;
        end
    end

    // ---- stage 2 / control: valids, output state and flip counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            m_out     <= 1'b0;
            last_m    <= 1'b0;
            flip_cnt  <= '0;
        end else begin
            if (adv1)
                vld_p1 <= in_valid;
            if (adv2) begin
                out_valid <= vld_p1;
                if (vld_p1)
                    m_out <= m_p1;
            end
            if (cnt_clr)
                flip_cnt <= '0;
            else if (out_xfer && (m_out != last_m))
                flip_cnt <= sat_inc(flip_cnt);
            if (out_xfer)
                last_m <= m_out;
        end
    end

endmodule

// File: doc/pbit_sampler.md
Name: pbit_sampler

Overview:
- Downstream consumer of the 32-bit LFSR random word. Turns a signed synaptic input I into a binary p-bit state m in {-1,+1}.
- Math: m = sgn(tanh(beta*I) - r). tanh is approximated by a hard clamp; r is taken from the LFSR word.
- Two-stage valid/ready pipeline with a force-clamp override and a saturating flip counter. Sits between the synapse accumulator and the p-bit state register file.

Parameters:
- I_W, 16, width of signed input I (two's complement)
- I_FRAC, 8, fractional bits of I; also sets comparator width (I_FRAC+1)
- BETA_W, 8, width of unsigned inverse temperature beta
- BETA_FRAC, 4, fractional bits of beta
- CNT_W, 16, width of flip counter

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  I/beta presented
- in_ready  out  1  stage 1 can accept
- in_i  in  I_W  signed input, Q(I_W-I_FRAC).I_FRAC
- in_beta  in  BETA_W  unsigned beta, Q.BETA_FRAC
- rnd  in  32  LFSR word, sampled on S1->S2 transfer
- clamp_en  in  1  force output, sampled with in_i
- clamp_val  in  1  forced value (1 = +1)
- out_valid  out  1  m_out valid
- out_ready  in  1  consumer accepts m_out
- m_out  out  1  p-bit state, 1 = +1, 0 = -1
- flip_cnt  out  CNT_W  count of m_out value changes, saturating
- cnt_clr  in  1  synchronous clear of flip_cnt

Behaviour:
- Reset (async, reset_n=0):
  - in_ready=1, out_valid=0, m_out=0, flip_cnt=0.
  - Internal valids and the last-state register are cleared.
  - Reset mid-operation discards in-flight data; no output is produced for it.
- Handshake:
  - Transfer on valid&ready.
  - adv2 = ~out_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1, combinational from registered state and out_ready.
  - While out_valid=1 and out_ready=0: m_out, out_valid and all stages hold.
- Stage 1 (on input transfer):
  - p = in_i * in_beta, signed x unsigned, width I_W+BETA_W+1.
  - x = p >>> BETA_FRAC (arithmetic, floor toward -inf).
  - t = clamp(x, -2^I_FRAC, 2^I_FRAC - 1), registered as I_FRAC+1 signed bits.
  - clamp_en and clamp_val are registered alongside.
  - s1_valid set.
  - If adv1=1 with no input transfer, s1_valid clears.
- Stage 2 (when adv2 and s1_valid):
  - r = signed rnd[31:31-I_FRAC].
  - m = clamp_en_s1 ? clamp_val_s1 : (t > r), strict signed greater-than.
  - Register m into m_out; out_valid=1.
  - If adv2=1 and s1_valid=0, out_valid clears.
- Latency:
  - Input accepted at cycle n gives out_valid at n+2 with no stall.
  - Sustains one result per cycle when out_ready=1.
- Probability: t=-2^I_FRAC gives m=+1 with probability 0. t=2^I_FRAC-1 gives probability (2^(I_FRAC+1)-1)/2^(I_FRAC+1).
- flip_cnt:
  - Updates on each output transfer (out_valid&out_ready).
  - Increments if m_out differs from the previously transferred value. The first transfer after reset compares against 0.
  - Saturates at 2^CNT_W-1, no wrap.
  - cnt_clr has priority over increment. If both occur in the same cycle, flip_cnt=0.
- Arithmetic corner: in_i = -2^(I_W-1) with beta = 2^BETA_W-1 must not overflow p (extra sign bit covers it).

Test Plan:
- Reset then idle: in_ready=1, out_valid=0, m_out=0, flip_cnt=0. Assert reset_n=0 mid-stream with 2 items in flight -> no out_valid after release until a new input is accepted.
- Latency and arithmetic:
  - in_i=0x0100 (1.0), beta=0x10 (1.0), rnd=0x00000000 at the S1->S2 cycle -> t=255>0, m_out=1 two cycles after accept.
  - Same input with rnd=0x7FC00000 (r=255) -> m_out=0.
- Saturation:
  - in_i=0x8000, beta=0xFF -> t=-256. 1000 random rnd words give m_out=0 every time.
  - in_i=0x7FFF, beta=0xFF -> t=255.
- Clamp: clamp_en=1, clamp_val=1, in_i=0x8000 -> m_out=1 regardless of rnd.
- Backpressure: stream 4 inputs, hold out_ready=0 for 5 cycles -> m_out stable, in_ready=0 once both stages are full. Release -> 4 outputs in order with no loss or duplication.
- Flip counter:
  - Output sequence 1,1,0,1 -> flip_cnt=3.
  - Preload near max with CNT_W=4, alternating outputs -> stops at 15.
  - cnt_clr coincident with a flip -> 0.
